// File: rtl/ysyx_24080014_mem_responder_if.sv
// Request/response bundle between the memory stage and the memory responder.
// The requester drives valid plus the qualifiers and data; the responder returns a one-cycle mem_ready strobe with dout.
interface ysyx_24080014_mem_responder_if;
  logic        valid;
  logic        ren;
  logic        wen;
  logic [7:0]  wmask;
  logic [31:0] raddr;
  logic [31:0] waddr;
  logic [31:0] din;
  logic        mem_ready;
  logic [31:0] dout;

  modport master (
    output valid, ren, wen, wmask, raddr, waddr, din,
    input  mem_ready, dout
  );

  modport slave (
    input  valid, ren, wen, wmask, raddr, waddr, din,
    output mem_ready, dout
  );
endinterface

// File: rtl/ysyx_24080014_mem_responder.sv
// Fixed-latency word memory with byte-lane writes and byte-aligned reads.
// One request is in flight at a time; state is exported on state_dbg.
module ysyx_24080014_mem_responder #(
  parameter int LATENCY = 2,
  parameter int AW      = 8
) (
  input  logic       clk,
  input  logic       rst,
  ysyx_24080014_mem_responder_if.slave bus,
  output logic [1:0] state_dbg
);

  // Handshake: a request is taken on a rising edge in IDLE when valid=1 and
  // (ren|wen)=1; mem_ready pulses for exactly one cycle, LATENCY+1 edges later.
  // Anything presented while BUSY or RESP is dropped, never queued.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            accept;
  logic            enter_resp;

  logic            ren_q, wen_q;
  logic [AW+1:0]   raddr_q, waddr_q;
  logic [31:0]     din_q;
  logic [3:0]      wmask_q;
  logic [31:0]     dout_q;

  logic            op_ren, op_wen;
  logic [AW+1:0]   op_raddr, op_waddr;
  logic [31:0]     op_din;
  logic [3:0]      op_wmask;
  logic [3:0]      be_sh;
  logic [31:0]     wdata_sh;

  logic [31:0]     mem [2**AW];

  logic            unused_bits;
  assign unused_bits = ^{bus.wmask[7:4], bus.raddr[31:AW+2], bus.waddr[31:AW+2]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.valid && (bus.ren || bus.wen)) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    enter_resp = (state_d == RESP) && (state_q != RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      raddr_q <= '0;
      waddr_q <= '0;
      din_q   <= '0;
      wmask_q <= '0;
    end else if (accept) begin
      ren_q   <= bus.ren;
      wen_q   <= bus.wen;
      raddr_q <= bus.raddr[AW+1:0];
      waddr_q <= bus.waddr[AW+1:0];
      din_q   <= bus.din;
      wmask_q <= bus.wmask[3:0];
    end
  end

  // With LATENCY=0 RESP is entered on the accepting edge, so the live inputs are the operands.
  always_comb begin
    if (state_q == IDLE) begin
      op_ren   = bus.ren;
      op_wen   = bus.wen;
      op_raddr = bus.raddr[AW+1:0];
      op_waddr = bus.waddr[AW+1:0];
      op_din   = bus.din;
      op_wmask = bus.wmask[3:0];
    end else begin
      op_ren   = ren_q;
      op_wen   = wen_q;
      op_raddr = raddr_q;
      op_waddr = waddr_q;
      op_din   = din_q;
      op_wmask = wmask_q;
    end
  end

  // Lanes shifted beyond byte 3 fall off the top rather than wrapping.
  assign be_sh    = op_wmask << op_waddr[1:0];
  assign wdata_sh = op_din << {op_waddr[1:0], 3'b000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= 32'd0;
    end else if (enter_resp && op_ren) begin
      dout_q <= mem[op_raddr[AW+1:2]] >> {op_raddr[1:0], 3'b000};
    end
  end

  // Storage has no reset; the read above sees the pre-write word.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && op_wen) begin
      for (int j = 0; j < 4; j++) begin
        if (be_sh[j]) mem[op_waddr[AW+1:2]][8*j +: 8] <= wdata_sh[8*j +: 8];
      end
    end
  end

  assign bus.mem_ready = (state_q == RESP);
  assign bus.dout      = dout_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_ysyx_24080014_mem_responder.sv
// Directed bench for the memory responder: LATENCY=2 instance for the main
// behaviour, LATENCY=0 instance for the zero-wait path and address wrap.
module tb_ysyx_24080014_mem_responder;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        req_valid, req_ren, req_wen;
  logic [7:0]  req_wmask;
  logic [31:0] req_raddr, req_waddr, req_din;
  logic [1:0]  state_dbg, state_dbg0;
  int          n_checks;
  int          n_errors;

  ysyx_24080014_mem_responder_if bus();
  ysyx_24080014_mem_responder_if bus0();

  assign bus.valid  = req_valid & ~sel;
  assign bus.ren    = req_ren;
  assign bus.wen    = req_wen;
  assign bus.wmask  = req_wmask;
  assign bus.raddr  = req_raddr;
  assign bus.waddr  = req_waddr;
  assign bus.din    = req_din;
  assign bus0.valid = req_valid & sel;
  assign bus0.ren   = req_ren;
  assign bus0.wen   = req_wen;
  assign bus0.wmask = req_wmask;
  assign bus0.raddr = req_raddr;
  assign bus0.waddr = req_waddr;
  assign bus0.din   = req_din;

  logic        mr_obs;
  logic [31:0] dout_obs;
  assign mr_obs   = sel ? bus0.mem_ready : bus.mem_ready;
  assign dout_obs = sel ? bus0.dout : bus.dout;

  ysyx_24080014_mem_responder #(.LATENCY(2), .AW(8)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .state_dbg(state_dbg)
  );

  ysyx_24080014_mem_responder #(.LATENCY(0), .AW(8)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave), .state_dbg(state_dbg0)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic do_req(input logic r, input logic w, input logic [31:0] ra,
                        input logic [31:0] wa, input logic [31:0] d, input logic [7:0] m,
                        input int exp_lat, input string tag);
    int lat;
    req_valid = 1'b1;
    req_ren   = r;
    req_wen   = w;
    req_raddr = ra;
    req_waddr = wa;
    req_din   = d;
    req_wmask = m;
    @(posedge clk);
    #1;
    // Scramble everything after acceptance; the pending op must not notice.
    req_valid = 1'b0;
    req_ren   = 1'($urandom_range(0, 1));
    req_wen   = 1'($urandom_range(0, 1));
    req_raddr = $urandom;
    req_waddr = $urandom;
    req_din   = $urandom;
    req_wmask = 8'($urandom_range(0, 255));
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mr_obs) begin
        lat = k;
        break;
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, mr_obs}, 32'd0);
  endtask

  initial begin
    int pulses, consec, gap_err, prev, cnt;
    logic last;
    n_checks  = 0;
    n_errors  = 0;
    sel       = 1'b0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_ren   = 1'b0;
    req_wen   = 1'b0;
    req_wmask = 8'd0;
    req_raddr = 32'd0;
    req_waddr = 32'd0;
    req_din   = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, bus.mem_ready}, 32'd0);
    check("rst_dout", bus.dout, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    rst = 1'b0;

    // full-word write then read
    do_req(1'b0, 1'b1, 32'h0, 32'h10, 32'hDEADBEEF, 8'h0F, 3, "wr10");
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 8'h00, 3, "rd10");
    check("rd10_dout", dout_obs, 32'hDEADBEEF);

    // single-lane write at byte offset 2, then byte-offset read
    do_req(1'b0, 1'b1, 32'h0, 32'h12, 32'h000000AA, 8'h01, 3, "wr12");
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 8'h00, 3, "rd10b");
    check("rd10b_dout", dout_obs, 32'hDEAABEEF);
    do_req(1'b1, 1'b0, 32'h13, 32'h0, 32'h0, 8'h00, 3, "rd13");
    check("rd13_dout", dout_obs, 32'h000000DE);

    // offset-3 write keeps only lane 0 (lands in byte 3); dout untouched by writes
    do_req(1'b0, 1'b1, 32'h0, 32'h13, 32'h44332211, 8'h0F, 3, "wr13");
    check("wr_keeps_dout", dout_obs, 32'h000000DE);
    // empty low mask (upper bits ignored) still handshakes, changes nothing
    do_req(1'b0, 1'b1, 32'h0, 32'h10, 32'hFFFFFFFF, 8'hF0, 3, "wrm0");
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 8'h00, 3, "rd10c");
    check("rd10c_dout", dout_obs, 32'h11AABEEF);

    // combined read+write returns old data, then write is visible
    do_req(1'b0, 1'b1, 32'h0, 32'h10, 32'h11223344, 8'h0F, 3, "wr10d");
    do_req(1'b1, 1'b1, 32'h10, 32'h10, 32'h55667788, 8'h0F, 3, "rw10");
    check("rw10_dout", dout_obs, 32'h11223344);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 8'h00, 3, "rd10e");
    check("rd10e_dout", dout_obs, 32'h55667788);

    // valid with no qualifier is ignored
    req_valid = 1'b1;
    req_ren   = 1'b0;
    req_wen   = 1'b0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (mr_obs) cnt++;
    end
    check("noop_ready", 32'(cnt), 32'd0);
    check("noop_state", {30'd0, state_dbg}, 32'd0);

    // held valid read: one pulse every LATENCY+2 cycles
    req_ren   = 1'b1;
    req_raddr = 32'h10;
    pulses = 0; consec = 0; gap_err = 0; prev = -1; last = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mr_obs) begin
        pulses++;
        if (last) consec++;
        if (prev > 0 && (k - prev) != 4) gap_err++;
        prev = k;
      end
      last = mr_obs;
    end
    req_valid = 1'b0;
    req_ren   = 1'b0;
    check("held_pulses", 32'(pulses), 32'd5);
    check("held_consec", 32'(consec), 32'd0);
    check("held_gap", 32'(gap_err), 32'd0);
    check("held_last", 32'(prev), 32'd19);

    // reset in BUSY aborts a pending write
    do_req(1'b0, 1'b1, 32'h0, 32'h20, 32'hCAFEF00D, 8'h0F, 3, "wr20");
    do_req(1'b1, 1'b0, 32'h20, 32'h0, 32'h0, 8'h00, 3, "rd20");
    check("rd20_dout", dout_obs, 32'hCAFEF00D);
    req_valid = 1'b1;
    req_ren   = 1'b0;
    req_wen   = 1'b1;
    req_waddr = 32'h20;
    req_din   = 32'h12345678;
    req_wmask = 8'h0F;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wen   = 1'b0;
    check("busy_state", {30'd0, state_dbg}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("abort_ready", {31'd0, bus.mem_ready}, 32'd0);
    check("abort_dout", bus.dout, 32'd0);
    check("abort_state", {30'd0, state_dbg}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_req(1'b1, 1'b0, 32'h20, 32'h0, 32'h0, 8'h00, 3, "rd20b");
    check("rd20b_dout", dout_obs, 32'hCAFEF00D);

    // zero-latency instance: word 0 reached through a wrapped address
    sel = 1'b1;
    do_req(1'b0, 1'b1, 32'h0, 32'h0, 32'h0BADF00D, 8'h0F, 1, "l0_wr");
    do_req(1'b1, 1'b0, 32'h400, 32'h0, 32'h0, 8'h00, 1, "l0_rd");
    check("l0_rd_dout", dout_obs, 32'h0BADF00D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ysyx_24080014_mem_responder.md
YSYX_24080014_MEM_RESPONDER -- requirements
Module: ysyx_24080014_mem_responder

Interface
REQ-001 Parameter LATENCY, default 2, wait cycles between request acceptance and response; legal range 0..15.
REQ-002 Parameter AW, default 8, word-address width; storage SHALL hold 2^AW 32-bit words.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 valid  input  1  request strobe from the memory stage.
REQ-006 ren  input  1  read request qualifier.
REQ-007 wen  input  1  write request qualifier.
REQ-008 wmask  input  8  byte-lane write mask; bits [3:0] select lanes, bits [7:4] ignored.
REQ-009 raddr  input  32  read byte address.
REQ-010 waddr  input  32  write byte address.
REQ-011 din  input  32  write data, byte 0 in [7:0].
REQ-012 mem_ready  output  1  one-cycle response strobe.
REQ-013 dout  output  32  read data, addressed byte in [7:0].

Function
REQ-014 FSM states SHALL be IDLE, BUSY and RESP.
REQ-015 In IDLE, valid=1 with ren|wen=1 SHALL be accepted on the clock edge, latching raddr, waddr, din, wmask, ren and wen.
REQ-016 valid=1 with ren=wen=0 SHALL be ignored; FSM stays in IDLE.
REQ-017 On acceptance the FSM SHALL go to BUSY with a latency counter loaded with LATENCY-1 when LATENCY>0, or directly to RESP when LATENCY=0.
REQ-018 BUSY SHALL decrement the counter each cycle and go to RESP on the cycle after the counter reads 0.
REQ-019 mem_ready SHALL be 1 exactly during RESP (one cycle); RESP SHALL always return to IDLE.
REQ-020 Latency: mem_ready is high LATENCY+1 cycles after the accepting edge.
REQ-021 Inputs in BUSY and RESP SHALL be ignored; no queuing; a held valid is re-accepted in the first IDLE cycle after RESP.
REQ-022 Input changes after acceptance SHALL NOT affect the pending operation.
REQ-023 Word index = addr[AW+1:2]; higher address bits are discarded, so addresses wrap modulo 2^(AW+2).
REQ-024 Read: on entry to RESP, dout SHALL load word[raddr] logically shifted right by 8*raddr[1:0]; the vacated upper bytes are zero.
REQ-025 dout SHALL hold its value until the next read completes; write-only operations SHALL NOT change dout.
REQ-026 Write: on entry to RESP, for each lane i with wmask[i]=1 and i+waddr[1:0]<=3, byte i of din SHALL be written to byte lane i+waddr[1:0] of word[waddr].
REQ-027 Lanes shifted past byte 3 SHALL be dropped; there is no wrap into the next word.
REQ-028 wmask[3:0]=0 with wen=1 SHALL complete the handshake without modifying storage.
REQ-029 ren=wen=1 in one request: the read SHALL return pre-write data, and the write SHALL then be applied in the same RESP entry.
REQ-030 Sign/zero extension is the requester's job; the responder performs none.

Reset
REQ-031 On rst=1, asynchronously: state=IDLE, counter=0, mem_ready=0, dout=0.
REQ-032 Storage contents SHALL NOT be reset.
REQ-033 Reset during BUSY SHALL abort the operation; the pending write SHALL NOT be applied.
REQ-034 After rst deasserts, the first request SHALL be accepted on the first rising edge with rst=0.

Verification
REQ-035 LATENCY=2: write waddr=0x10, din=0xDEADBEEF, wmask=0x0F -> mem_ready high on edge 3 after acceptance; a following read of raddr=0x10 -> dout=0xDEADBEEF with mem_ready.
REQ-036 Word 4 = 0xDEADBEEF; write waddr=0x12, din=0x000000AA, wmask=0x01 -> word 4=0xDEAABEEF; read raddr=0x13 -> dout=0x000000DE.
REQ-037 Word 4 = 0x11223344; a request with ren=wen=1, raddr=waddr=0x10, din=0x55667788, wmask=0x0F -> dout=0x11223344; a subsequent read -> 0x55667788.
REQ-038 valid held high continuously with ren=1 -> mem_ready pulses once every LATENCY+2 cycles, never two consecutive cycles.
REQ-039 Assert rst in the BUSY of a write to 0x20 -> mem_ready and dout=0 immediately; word 8 is unchanged afterwards.
REQ-040 LATENCY=0 and AW=8: read raddr=0x400 -> mem_ready on the next edge; dout equals word 0 (address wrap).
